alu_control_dm: RTL and testbench

- Single-cycle execute/memory slice of the 5-stage MIPS32 pipeline.
- Combines three functions:
  - Opcode/funct decoder producing the pipeline control bits.
  - 32-bit ALU with zero flag.
  - Word-addressed data memory with synchronous write and combinational read.
- The ALU result addresses the data memory.
- The write-back value is selected between ALU result and memory read data.

---
 rtl/alu_control_dm.sv | 253 +++++++++++++++++++++++++
 tb/tb_alu_control_dm.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_dm.sv
// alu_control_dm: single-cycle execute/memory slice of a 5-stage MIPS32 pipeline.
//
// Combines three functions:
//   - Main/ALU decoder: opcode and funct produce the pipeline control bits.
//   - 32-bit ALU with zero flag.
//   - Word-addressed data memory: synchronous write, combinational read.
// The ALU result addresses the data memory. wb_data selects between the ALU
// result and the memory read data.
//
// Optional feature (macro ALU_OVF_EN):
//   Adds output ovf, the signed overflow of add/sub ALU operations. An
//   overflowing R-type add/sub has its regwrite forced to 0.
//   With the macro undefined the port is absent and arithmetic wraps silently.
//
// Parameters:
//   DM_WORDS  data-memory depth in 32-bit words (power of two, >= 2)
//   DM_AW     word-index width, log2(DM_WORDS)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset; clears memory, blocks writes
//   opcode     instruction[31:26]
//   funct      instruction[5:0]
//   rs_data    ALU operand A
//   rt_data    register operand B; also the store data
//   seimm      sign-extended immediate
//   regdst     destination register is rd (1) or rt (0)
//   branch_eq  beq
//   branch_ne  bne
//   jump       j
//   memread    load
//   memwrite   store
//   memtoreg   write-back source is memory
//   regwrite   register-file write enable
//   alusrc     ALU B is seimm (1) or rt_data (0)
//   aluctl     decoded ALU operation
//   alu_out    ALU result
//   zero       alu_out == 0
//   ovf        signed overflow of add/sub (only with ALU_OVF_EN)
//   rdata      memory read data (0 unless memread and not in reset)
//   wb_data    memtoreg ? rdata : alu_out

module alu_control_dm #(
  parameter int unsigned DM_WORDS = 32,
  parameter int unsigned DM_AW    = $clog2(DM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] seimm,
  output logic        regdst,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        jump,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrc,
  output logic [3:0]  aluctl,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic [31:0] rdata,
`ifdef ALU_OVF_EN
  output logic        ovf,
`endif
  output logic [31:0] wb_data
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnNor = 6'b100111;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic regwrite_dec;

  always_comb begin
    regdst       = 1'b0;
    branch_eq    = 1'b0;
    branch_ne    = 1'b0;
    jump         = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    memtoreg     = 1'b0;
    regwrite_dec = 1'b0;
    alusrc       = 1'b0;
    aluctl       = AluAnd;

    unique case (opcode)
      OpRType: begin
        // Only recognised functs enable the register write; nop and any
        // unsupported funct leave every control at 0.
        unique case (funct)
          FnAdd: aluctl = AluAdd;
          FnSub: aluctl = AluSub;
          FnAnd: aluctl = AluAnd;
          FnOr:  aluctl = AluOr;
          FnSlt: aluctl = AluSlt;
          FnNor: aluctl = AluNor;
          default: aluctl = AluAnd;
        endcase
        unique case (funct)
          FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnNor: begin
            regdst       = 1'b1;
            regwrite_dec = 1'b1;
          end
          default: ;
        endcase
      end
      OpLw: begin
        alusrc       = 1'b1;
        memread      = 1'b1;
        memtoreg     = 1'b1;
        regwrite_dec = 1'b1;
        aluctl       = AluAdd;
      end
      OpSw: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
        aluctl   = AluAdd;
      end
      OpBeq: begin
        branch_eq = 1'b1;
        aluctl    = AluSub;
      end
      OpBne: begin
        branch_ne = 1'b1;
        aluctl    = AluSub;
      end
      OpAddi: begin
        alusrc       = 1'b1;
        regwrite_dec = 1'b1;
        aluctl       = AluAdd;
      end
      OpSlti: begin
        alusrc       = 1'b1;
        regwrite_dec = 1'b1;
        aluctl       = AluSlt;
      end
      OpJ: begin
        jump   = 1'b1;
        aluctl = AluAnd;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] add_res;
  logic [31:0] sub_res;

  assign alu_a   = rs_data;
  assign alu_b   = alusrc ? seimm : rt_data;
  assign add_res = alu_a + alu_b;
  assign sub_res = alu_a - alu_b;

  always_comb begin
    alu_out = '0;
    unique case (aluctl)
      AluAnd:  alu_out = alu_a & alu_b;
      AluOr:   alu_out = alu_a | alu_b;
      AluAdd:  alu_out = add_res;
      AluSub:  alu_out = sub_res;
      AluSlt:  alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      AluNor:  alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
  end

  assign zero = (alu_out == 32'd0);

`ifdef ALU_OVF_EN
  logic add_ovf;
  logic sub_ovf;
  logic rtype_arith;

  // add: same-sign operands producing a different-sign result.
  // sub: different-sign operands where the result sign departs from A.
  assign add_ovf = (alu_a[31] == alu_b[31]) && (add_res[31] != alu_a[31]);
  assign sub_ovf = (alu_a[31] != alu_b[31]) && (sub_res[31] != alu_a[31]);

  always_comb begin
    ovf = 1'b0;
    unique case (aluctl)
      AluAdd:  ovf = add_ovf;
      AluSub:  ovf = sub_ovf;
      default: ovf = 1'b0;
    endcase
  end

  assign rtype_arith = (opcode == OpRType) && ((funct == FnAdd) || (funct == FnSub));
  assign regwrite    = regwrite_dec & ~(ovf & rtype_arith);
`else
  assign regwrite = regwrite_dec;
`endif

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_q [DM_WORDS];
  logic [DM_AW-1:0] mem_idx;

  // Byte-offset bits and everything above the index are dropped, so the
  // address space wraps modulo DM_WORDS*4.
  assign mem_idx = alu_out[DM_AW+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DM_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (memwrite) begin
      mem_q[mem_idx] <= rt_data;
    end
  end

  // Combinational read sees the pre-edge contents, so a word written this
  // cycle is only observed from the next cycle.
  assign rdata   = (memread && !reset) ? mem_q[mem_idx] : 32'd0;
  assign wb_data = memtoreg ? rdata : alu_out;

endmodule

// File: tb/tb_alu_control_dm.sv
module tb_alu_control_dm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] seimm;
  logic        regdst, branch_eq, branch_ne, jump, memread, memwrite;
  logic        memtoreg, regwrite, alusrc, zero;
  logic [3:0]  aluctl;
  logic [31:0] alu_out, rdata, wb_data;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  alu_control_dm dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .seimm     (seimm),
    .regdst    (regdst),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .jump      (jump),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrc    (alusrc),
    .aluctl    (aluctl),
    .alu_out   (alu_out),
    .zero      (zero),
    .rdata     (rdata),
`ifdef ALU_OVF_EN
    .ovf       (ovf),
`endif
    .wb_data   (wb_data)
  );

  // ctl order: regdst, beq, bne, jump, memread, memwrite, memtoreg, regwrite, alusrc, aluctl
  typedef struct packed {
    logic [12:0] ctl;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] rdata;
    logic [31:0] wb;
  } obs_t;

  obs_t obs;
  assign obs = {regdst, branch_eq, branch_ne, jump, memread, memwrite, memtoreg, regwrite,
                alusrc, aluctl, alu_out, zero, rdata, wb_data};

  localparam logic [12:0] C_NONE = 13'b0000_0000_0_0000;
  localparam logic [12:0] C_ADD  = 13'b1000_0001_0_0010;
  localparam logic [12:0] C_SUB  = 13'b1000_0001_0_0110;
  localparam logic [12:0] C_AND  = 13'b1000_0001_0_0000;
  localparam logic [12:0] C_OR   = 13'b1000_0001_0_0001;
  localparam logic [12:0] C_SLT  = 13'b1000_0001_0_0111;
  localparam logic [12:0] C_NOR  = 13'b1000_0001_0_1100;
  localparam logic [12:0] C_LW   = 13'b0000_1011_1_0010;
  localparam logic [12:0] C_SW   = 13'b0000_0100_1_0010;
  localparam logic [12:0] C_BEQ  = 13'b0100_0000_0_0110;
  localparam logic [12:0] C_BNE  = 13'b0010_0000_0_0110;
  localparam logic [12:0] C_ADDI = 13'b0000_0001_1_0010;
  localparam logic [12:0] C_SLTI = 13'b0000_0001_1_0111;
  localparam logic [12:0] C_J    = 13'b0001_0000_0_0000;

  localparam logic [5:0] OP_R = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    obs_t        exp;
  } step_t;

  step_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic step_t mk(input string name, input logic [5:0] op, input logic [5:0] fn,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] imm, input logic [12:0] ctl,
                               input logic [31:0] alu, input logic [31:0] rd,
                               input logic [31:0] wb);
    step_t s;
    s.name = name;
    s.op   = op;
    s.fn   = fn;
    s.rs   = rs;
    s.rt   = rt;
    s.imm  = imm;
    s.exp  = '{ctl: ctl, alu: alu, zero: (alu == 32'd0), rdata: rd, wb: wb};
    return s;
  endfunction

  // Applies a step's inputs and queues its expected outputs.
  task automatic drive(input step_t s);
    opcode  = s.op;
    funct   = s.fn;
    rs_data = s.rs;
    rt_data = s.rt;
    seimm   = s.imm;
    sb_q.push_back(s);
  endtask

  task automatic test_reset();
    step_t s;
    reset = 1'b1;
    drive(mk("reset_lw5_in_reset", OP_LW, 6'd0, 32'd0, 32'd0, 32'd20, C_LW, 32'd20, 0, 0));
    #1;
    s = sb_q.pop_front();
    checks++;
    if (obs !== s.exp) begin
      errors++;
      $display("FAIL %s got %h want %h", s.name, obs, s.exp);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(mk("reset_lw5_after", OP_LW, 6'd0, 32'd0, 32'd0, 32'd20, C_LW, 32'd20, 0, 0));
    #1;
    s = sb_q.pop_front();
    checks++;
    if (obs !== s.exp) begin
      errors++;
      $display("FAIL %s got %h want %h", s.name, obs, s.exp);
    end
  endtask

  task automatic test_mem();
    step_t v[$];
    step_t s;
    v.push_back(mk("sw_108", OP_SW, 6'd0, 32'h100, 32'hDEADBEEF, 32'd8, C_SW,
                   32'h108, 0, 32'h108));
    v.push_back(mk("lw_108", OP_LW, 6'd0, 32'h100, 32'h0, 32'd8, C_LW,
                   32'h108, 32'hDEADBEEF, 32'hDEADBEEF));
    v.push_back(mk("lw_idx2_direct", OP_LW, 6'd0, 32'h8, 32'h0, 32'd0, C_LW,
                   32'h8, 32'hDEADBEEF, 32'hDEADBEEF));
    v.push_back(mk("lw_byte_off", OP_LW, 6'd0, 32'hB, 32'h0, 32'd0, C_LW,
                   32'hB, 32'hDEADBEEF, 32'hDEADBEEF));
    v.push_back(mk("lw_wrap_8a", OP_LW, 6'd0, 32'h0, 32'h0, 32'h8A, C_LW,
                   32'h8A, 32'hDEADBEEF, 32'hDEADBEEF));
    v.push_back(mk("add_no_memread", OP_R, 6'b100000, 32'h8, 32'h0, 32'h0, C_ADD,
                   32'h8, 0, 32'h8));
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      s = sb_q.pop_front();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", s.name, obs, s.exp);
      end
    end
  endtask

  task automatic test_decode_alu();
    step_t v[$];
    step_t s;
    v.push_back(mk("sub_eq", OP_R, 6'b100010, 32'd7, 32'd7, 32'h55, C_SUB, 0, 0, 0));
    v.push_back(mk("beq", 6'b000100, 6'd0, 32'd7, 32'd7, 32'h55, C_BEQ, 0, 0, 0));
    v.push_back(mk("bne", 6'b000101, 6'd0, 32'd7, 32'd8, 32'h55, C_BNE,
                   32'hFFFFFFFF, 0, 32'hFFFFFFFF));
    v.push_back(mk("slt_neg1_1", OP_R, 6'b101010, 32'hFFFFFFFF, 32'd1, 0, C_SLT, 1, 0, 1));
    v.push_back(mk("slt_min_max", OP_R, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 0, C_SLT,
                   1, 0, 1));
    v.push_back(mk("slt_max_min", OP_R, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 0, C_SLT,
                   0, 0, 0));
    v.push_back(mk("nor_zero", OP_R, 6'b100111, 0, 0, 32'h1, C_NOR,
                   32'hFFFFFFFF, 0, 32'hFFFFFFFF));
    v.push_back(mk("add_wrap", OP_R, 6'b100000, 32'hFFFFFFFF, 32'd2, 32'h40, C_ADD, 1, 0, 1));
    v.push_back(mk("and", OP_R, 6'b100100, 32'hF0F0, 32'hFF00, 32'h1234, C_AND,
                   32'hF000, 0, 32'hF000));
    v.push_back(mk("or", OP_R, 6'b100101, 32'hF0F0, 32'hFF00, 32'h1234, C_OR,
                   32'hFFF0, 0, 32'hFFF0));
    v.push_back(mk("addi_neg", 6'b001000, 6'd0, 32'd10, 32'd99, 32'hFFFFFFFD, C_ADDI,
                   32'd7, 0, 32'd7));
    v.push_back(mk("slti_neg", 6'b001010, 6'd0, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFD, C_SLTI,
                   1, 0, 1));
    v.push_back(mk("jump", 6'b000010, 6'd0, 32'hFF, 32'h0F, 32'h0, C_J, 32'h0F, 0, 32'h0F));
    v.push_back(mk("unknown_op", 6'b111111, 6'b100000, 32'hFF, 32'h3C, 32'h1, C_NONE,
                   32'h3C, 0, 32'h3C));
    v.push_back(mk("nop", OP_R, 6'b000000, 32'd6, 32'd3, 32'h0, C_NONE, 32'd2, 0, 32'd2));
    v.push_back(mk("r_bad_funct", OP_R, 6'b100001, 32'd6, 32'd3, 32'h0, C_NONE,
                   32'd2, 0, 32'd2));
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      s = sb_q.pop_front();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL %s got %h want %h", s.name, obs, s.exp);
      end
    end
  endtask

  task automatic test_reset_midrun();
    step_t s;
    // Store and read back index 3.
    @(negedge clk);
    drive(mk("mr_sw3", OP_SW, 6'd0, 32'd0, 32'h12345678, 32'd12, C_SW, 32'd12, 0, 32'd12));
    #1;
    s = sb_q.pop_front();
    checks++;
    if (obs !== s.exp) begin
      errors++;
      $display("FAIL %s got %h want %h", s.name, obs, s.exp);
    end
    @(negedge clk);
    drive(mk("mr_lw3_before", OP_LW, 6'd0, 32'd0, 32'd0, 32'd12, C_LW,
             32'd12, 32'h12345678, 32'h12345678));
    #1;
    s = sb_q.pop_front();
    checks++;
    if (obs !== s.exp) begin
      errors++;
      $display("FAIL %s got %h want %h", s.name, obs, s.exp);
    end
    // Assert reset between edges with a load pending, then hold a store
    // across a rising edge while reset is still high.
    #1;
    reset = 1'b1;
    #1;
    s = sb_q.size() == 0 ? mk("mr_lw3_in_reset", OP_LW, 6'd0, 32'd0, 32'd0, 32'd12, C_LW,
                              32'd12, 0, 0) : sb_q.pop_front();
    sb_q.push_back(s);
    s = sb_q.pop_front();
    checks++;
    if (obs !== s.exp) begin
      errors++;
      $display("FAIL %s got %h want %h", s.name, obs, s.exp);
    end
    drive(mk("mr_sw3_in_reset", OP_SW, 6'd0, 32'd0, 32'hCAFEF00D, 32'd12, C_SW,
             32'd12, 0, 32'd12));
    #1;
    s = sb_q.pop_front();
    checks++;
    if (obs !== s.exp) begin
      errors++;
      $display("FAIL %s got %h want %h", s.name, obs, s.exp);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(mk("mr_lw3_after", OP_LW, 6'd0, 32'd0, 32'd0, 32'd12, C_LW, 32'd12, 0, 0));
    #1;
    s = sb_q.pop_front();
    checks++;
    if (obs !== s.exp) begin
      errors++;
      $display("FAIL %s got %h want %h", s.name, obs, s.exp);
    end
    // First store after release lands on the next rising edge.
    @(negedge clk);
    drive(mk("mr_sw4", OP_SW, 6'd0, 32'd0, 32'hA5A5A5A5, 32'd16, C_SW, 32'd16, 0, 32'd16));
    #1;
    void'(sb_q.pop_front());
    @(negedge clk);
    drive(mk("mr_lw4", OP_LW, 6'd0, 32'd0, 32'd0, 32'd16, C_LW,
             32'd16, 32'hA5A5A5A5, 32'hA5A5A5A5));
    #1;
    s = sb_q.pop_front();
    checks++;
    if (obs !== s.exp) begin
      errors++;
      $display("FAIL %s got %h want %h", s.name, obs, s.exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] shadow [32];
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  idx;
    step_t       s;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int n = 0; n < 24; n++) begin
      // Store to a random index with random upper address bits (wrap).
      idx  = 5'($urandom_range(0, 31));
      data = $urandom;
      addr = ($urandom & 32'hFFFFFF80) | {25'd0, idx, 2'b00} | 32'($urandom_range(0, 3));
      @(negedge clk);
      drive(mk("b2b_sw", OP_SW, 6'd0, addr, data, 32'd0, C_SW, addr, 0, addr));
      shadow[idx] = data;
      #1;
      s = sb_q.pop_front();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL %s[%0d] got %h want %h", s.name, n, obs, s.exp);
      end
      idx  = 5'($urandom_range(0, 31));
      addr = ($urandom & 32'hFFFFFF80) | {25'd0, idx, 2'b00};
      @(negedge clk);
      drive(mk("b2b_lw", OP_LW, 6'd0, addr, 32'd0, 32'd0, C_LW, addr, shadow[idx],
               shadow[idx]));
      #1;
      s = sb_q.pop_front();
      checks++;
      if (obs !== s.exp) begin
        errors++;
        $display("FAIL %s[%0d] got %h want %h", s.name, n, obs, s.exp);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    opcode  = '0;
    funct   = '0;
    rs_data = '0;
    rt_data = '0;
    seimm   = '0;
    test_reset();
    test_mem();
    test_decode_alu();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
